// File: rtl/swc_gen.sv
// swc_gen: programmable up/down counter with byte-lane loads and a continuous count mode.
// Define SWC_GEN_RELOAD_EN to add a reload register and periodic down-count mode.
module swc_gen #(
    parameter int WIDTH = 24,
    parameter int BYTES = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      inst,
    input  logic             inst_en,
    output logic [WIDTH-1:0] counter,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             error
);
    typedef enum logic [1:0] {S_RESET, S_READY, S_ERROR} state_t;
    localparam logic [3:0] OP_NOP = 4'h0, OP_LDB = 4'h1, OP_COU = 4'h2, OP_COD = 4'h3,
                           OP_CCU = 4'h4, OP_CCD = 4'h5, OP_CCS = 4'h6, OP_CLR = 4'h7,
                           OP_LDR = 4'h8;
    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_counter, w_counter;
    logic             r_busy, w_busy, r_down, w_down, r_done, w_done;
    logic [3:0]       w_op, w_sel;
    logic [7:0]       w_imm;
    logic             w_lane_ok;
`ifdef SWC_GEN_RELOAD_EN
    logic [WIDTH-1:0] r_reload, w_reload;
`endif
    assign w_op      = inst[15:12];
    assign w_sel     = inst[11:8];
    assign w_imm     = inst[7:0];
    assign w_lane_ok = {28'd0, w_sel} < 32'(BYTES);
    always_comb begin
        w_state   = r_state;
        w_counter = r_counter;
        w_busy    = r_busy;
        w_down    = r_down;
        w_done    = 1'b0;
`ifdef SWC_GEN_RELOAD_EN
        w_reload  = r_reload;
`endif
        case (r_state)
            S_RESET: w_state = S_READY;
            S_READY:
                if (inst_en) begin
                    case (w_op)
                        OP_NOP: ;
                        OP_LDB:
                            if (w_lane_ok) begin
                                for (int b = 0; b < BYTES; b++)
                                    if (w_sel == 4'(b)) w_counter[b*8 +: 8] = w_imm;
                            end else w_state = S_ERROR;
                        OP_COU: begin
                            w_counter = r_counter + WIDTH'(1);
                            w_busy    = 1'b0;
                        end
                        OP_COD: begin
                            w_counter = r_counter - WIDTH'(1);
                            w_busy    = 1'b0;
                        end
                        OP_CCU: begin
                            w_counter = r_counter + WIDTH'(1);
                            w_busy    = 1'b1;
                            w_down    = 1'b0;
                        end
                        OP_CCD: begin
                            w_counter = r_counter - WIDTH'(1);
                            w_busy    = 1'b1;
                            w_down    = 1'b1;
                        end
                        OP_CCS: w_busy = 1'b0;
                        OP_CLR: begin
                            w_counter = '0;
                            w_busy    = 1'b0;
                        end
`ifdef SWC_GEN_RELOAD_EN
                        OP_LDR:
                            if (w_lane_ok) begin
                                for (int b = 0; b < BYTES; b++)
                                    if (w_sel == 4'(b)) w_reload[b*8 +: 8] = w_imm;
                            end else w_state = S_ERROR;
`endif
                        default: w_state = S_ERROR;
                    endcase
                end else if (r_busy) begin
                    if (r_counter != '0) w_counter = r_down ? r_counter - WIDTH'(1) : r_counter + WIDTH'(1);
                    else begin
                        w_done = 1'b1;
`ifdef SWC_GEN_RELOAD_EN
                        // Periodic mode: a non-zero reload restarts the down-count instead of stopping.
                        if (r_down && r_reload != '0) w_counter = r_reload;
                        else w_busy = 1'b0;
`else
                        w_busy = 1'b0;
`endif
                    end
                end
            default: w_state = S_ERROR;
        endcase
        if (w_state == S_ERROR) begin
            w_counter = '0;
            w_busy    = 1'b0;
            w_done    = 1'b0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_RESET;
            r_counter <= '0;
            r_busy    <= 1'b0;
            r_down    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SWC_GEN_RELOAD_EN
            r_reload  <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_counter <= w_counter;
            r_busy    <= w_busy;
            r_down    <= w_down;
            r_done    <= w_done;
`ifdef SWC_GEN_RELOAD_EN
            r_reload  <= w_reload;
`endif
        end
    end
    assign counter = r_counter;
    assign ready   = (r_counter == '0);
    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = (r_state == S_ERROR);
endmodule

// File: tb/tb_swc_gen.sv
// tb_swc_gen: directed scoreboard bench for swc_gen at WIDTH=24.
module tb_swc_gen;
    localparam logic [3:0] NOP = 4'h0, LDB = 4'h1, COU = 4'h2, COD = 4'h3, CCU = 4'h4,
                           CCD = 4'h5, CCS = 4'h6, CLR = 4'h7, LDR = 4'h8;
    logic        clock = 1'b0, reset = 1'b1, inst_en = 1'b0;
    logic [15:0] inst = '0;
    logic [23:0] counter;
    logic        ready, busy, done, error;
    int          n_checks = 0, n_fails = 0;
    typedef struct {
        string       tag;
        logic [23:0] c;
        logic        b, d, e;
    } exp_t;
    exp_t q[$];

    swc_gen dut (
        .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en),
        .counter(counter), .ready(ready), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] sel, input logic [7:0] imm);
        return {op, sel, imm};
    endfunction

    task automatic chk(input string tag, input string what, input logic [23:0] obs, input logic [23:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [15:0] ins, input logic [23:0] ec,
                        input logic eb, input logic ed, input logic ee, input string tag);
        exp_t x;
        @(negedge clock);
        reset = r; inst_en = en; inst = ins;
        x.tag = tag; x.c = ec; x.b = eb; x.d = ed; x.e = ee;
        q.push_back(x);
        @(posedge clock);
        #1;
        x = q.pop_front();
        chk(x.tag, "counter", counter, x.c);
        chk(x.tag, "busy", 24'(busy), 24'(x.b));
        chk(x.tag, "done", 24'(done), 24'(x.d));
        chk(x.tag, "error", 24'(error), 24'(x.e));
        chk(x.tag, "ready", 24'(ready), 24'(x.c == 24'h0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then an instruction in the Reset-state cycle is ignored
        step(1, 0, 16'h0,                 24'h000000, 0, 0, 0, "reset");
        step(0, 1, mk(LDB, 0, 8'h55),     24'h000000, 0, 0, 0, "rst_cycle_ignore");
        // Continuous down-count to zero
        step(0, 1, mk(LDB, 0, 8'h03),     24'h000003, 0, 0, 0, "ldb3");
        step(0, 1, mk(CCD, 0, 8'h00),     24'h000002, 1, 0, 0, "ccd_issue");
        step(0, 0, 16'h0,                 24'h000001, 1, 0, 0, "ccd_1");
        step(0, 0, 16'h0,                 24'h000000, 1, 0, 0, "ccd_0");
        step(0, 0, 16'h0,                 24'h000000, 0, 1, 0, "ccd_done");
        step(0, 0, 16'h0,                 24'h000000, 0, 0, 0, "ccd_done_once");
        // Byte lanes and wrap-around
        step(0, 1, mk(LDB, 2, 8'hFF),     24'hFF0000, 0, 0, 0, "ldb_lane2");
        step(0, 1, mk(LDB, 1, 8'hFF),     24'hFFFF00, 0, 0, 0, "ldb_lane1");
        step(0, 1, mk(LDB, 0, 8'hFE),     24'hFFFFFE, 0, 0, 0, "ldb_lane0");
        step(0, 1, mk(CCU, 0, 8'h00),     24'hFFFFFF, 1, 0, 0, "ccu_issue");
        step(0, 0, 16'h0,                 24'h000000, 1, 0, 0, "ccu_wrap");
        step(0, 0, 16'h0,                 24'h000000, 0, 1, 0, "ccu_done");
        step(0, 0, 16'h0,                 24'h000000, 0, 0, 0, "ccu_done_once");
        step(0, 1, mk(COD, 0, 8'h00),     24'hFFFFFF, 0, 0, 0, "cod_wrap");
        step(0, 1, mk(COU, 0, 8'h00),     24'h000000, 0, 0, 0, "cou_wrap");
        // CCS freezes, NOP neither steps nor cancels
        step(0, 1, mk(LDB, 0, 8'h10),     24'h000010, 0, 0, 0, "ldb10");
        step(0, 1, mk(CCU, 0, 8'h00),     24'h000011, 1, 0, 0, "ccu_11");
        step(0, 0, 16'h0,                 24'h000012, 1, 0, 0, "ccu_12");
        step(0, 1, mk(NOP, 0, 8'h00),     24'h000012, 1, 0, 0, "nop_hold");
        step(0, 0, 16'h0,                 24'h000013, 1, 0, 0, "ccu_13");
        step(0, 1, mk(CCS, 0, 8'h00),     24'h000013, 0, 0, 0, "ccs_stop");
        step(0, 0, 16'h0,                 24'h000013, 0, 0, 0, "ccs_frozen");
        // COU and CLR cancel continuous mode without done
        step(0, 1, mk(CCD, 0, 8'h00),     24'h000012, 1, 0, 0, "ccd_again");
        step(0, 1, mk(COU, 0, 8'h00),     24'h000013, 0, 0, 0, "cou_cancel");
        step(0, 0, 16'h0,                 24'h000013, 0, 0, 0, "cou_cancel_hold");
        step(0, 1, mk(CCD, 0, 8'h00),     24'h000012, 1, 0, 0, "ccd_clr");
        step(0, 1, mk(CLR, 0, 8'h00),     24'h000000, 0, 0, 0, "clr_cancel");
        step(0, 0, 16'h0,                 24'h000000, 0, 0, 0, "clr_no_done");
        // Reset mid-count
        step(0, 1, mk(LDB, 0, 8'h07),     24'h000007, 0, 0, 0, "ldb7");
        step(0, 1, mk(CCD, 0, 8'h00),     24'h000006, 1, 0, 0, "ccd_6");
        step(0, 0, 16'h0,                 24'h000005, 1, 0, 0, "ccd_5");
        step(1, 0, 16'h0,                 24'h000000, 0, 0, 0, "reset_mid");
        step(0, 1, mk(LDB, 0, 8'h33),     24'h000000, 0, 0, 0, "reset_state");
        step(0, 1, mk(LDB, 0, 8'h09),     24'h000009, 0, 0, 0, "ready_again");
        // Illegal lane and opcode
        step(0, 1, mk(LDB, 3, 8'h11),     24'h000000, 0, 0, 1, "ldb_bad_lane");
        step(0, 1, mk(LDB, 0, 8'h22),     24'h000000, 0, 0, 1, "err_ignore_ldb");
        step(0, 1, mk(CCU, 0, 8'h00),     24'h000000, 0, 0, 1, "err_ignore_ccu");
        step(1, 0, 16'h0,                 24'h000000, 0, 0, 0, "err_reset");
        step(0, 0, 16'h0,                 24'h000000, 0, 0, 0, "err_reset_state");
        step(0, 1, mk(LDB, 0, 8'h04),     24'h000004, 0, 0, 0, "ldb4");
        step(0, 1, mk(4'hF, 0, 8'h00),    24'h000000, 0, 0, 1, "op_f");
        step(0, 0, 16'h0,                 24'h000000, 0, 0, 1, "op_f_sticky");
        step(1, 0, 16'h0,                 24'h000000, 0, 0, 0, "reset2");
        step(0, 0, 16'h0,                 24'h000000, 0, 0, 0, "reset2_state");
`ifdef SWC_GEN_RELOAD_EN
        step(0, 1, mk(LDR, 0, 8'h02),     24'h000000, 0, 0, 0, "ldr2");
        step(0, 1, mk(LDB, 0, 8'h01),     24'h000001, 0, 0, 0, "ldb1");
        step(0, 1, mk(CCD, 0, 8'h00),     24'h000000, 1, 0, 0, "ccd_to0");
        step(0, 0, 16'h0,                 24'h000002, 1, 1, 0, "reload_a");
        step(0, 0, 16'h0,                 24'h000001, 1, 0, 0, "reload_a1");
        step(0, 0, 16'h0,                 24'h000000, 1, 0, 0, "reload_a0");
        step(0, 0, 16'h0,                 24'h000002, 1, 1, 0, "reload_b");
        step(0, 1, mk(CCS, 0, 8'h00),     24'h000002, 0, 0, 0, "reload_stop");
        step(0, 1, mk(LDR, 3, 8'h01),     24'h000000, 0, 0, 1, "ldr_bad_lane");
`else
        step(0, 1, mk(LDB, 0, 8'h05),     24'h000005, 0, 0, 0, "ldb5");
        step(0, 1, mk(LDR, 0, 8'h02),     24'h000000, 0, 0, 1, "ldr_illegal");
`endif
        step(1, 0, 16'h0,                 24'h000000, 0, 0, 0, "final_reset");
        if (q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
